// File: rtl/crc16_frame_ctrl.sv
// ----------------------------------------------------------------------------
// crc16_frame_ctrl
//
// Frame-level sequencer around a byte-wide CRC-16 engine
// (x^16 + x^12 + x^5 + 1, MSB-first, non-reflected, no final XOR).
// Upstream bytes are forwarded downstream through one output register stage.
// In generate mode the 2-byte CRC (high byte first) is appended to the frame.
// In check mode the frame already carries its trailer, and the residue is
// reported.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   mode      0 = generate, 1 = check; sampled on the first byte of a frame
//   s_valid   upstream byte valid
//   s_ready   upstream byte accepted when s_valid && s_ready
//   s_data    upstream byte
//   s_last    final byte of the upstream frame
//   m_valid   downstream byte valid
//   m_ready   downstream ready
//   m_data    downstream byte
//   m_last    final downstream byte of the frame
//   crc_out   final CRC of the last completed frame, held until next crc_done
//   crc_done  one-cycle pulse, the frame CRC is final
//   crc_err   valid with crc_done; check mode: residue != 0
//   busy      high whenever the sequencer is not idle
//
// State table
//   state  | meaning
//   IDLE   | waiting for the first byte of a frame
//   DATA   | mid-frame, forwarding payload bytes
//   CRC_HI | generate mode: emitting CRC high byte
//   CRC_LO | generate mode: emitting CRC low byte (carries m_last)
//   STAT   | check mode: one-cycle turnaround, CRC register reseeded
// ----------------------------------------------------------------------------
module crc16_frame_ctrl #(
    parameter logic [15:0] SEED      = 16'hFFFF,
    parameter int          DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATAWIDTH-1:0] s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_last,
    output logic [15:0]          crc_out,
    output logic                 crc_done,
    output logic                 crc_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        CRC_HI = 3'd2,
        CRC_LO = 3'd3,
        STAT   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   mode_q, mode_d;
    logic                   m_valid_q, m_valid_d;
    logic [DATAWIDTH-1:0]   m_data_q, m_data_d;
    logic                   m_last_q, m_last_d;
    logic [15:0]            crc_out_q, crc_out_d;
    logic                   crc_done_q, crc_done_d;
    logic                   crc_err_q, crc_err_d;

    logic                   out_free;
    logic                   accept;
    logic                   mode_eff;
    logic [15:0]            crc_next;

    // All bit-steps of one byte applied in a single cycle.
    function automatic logic [15:0] crc_step(input logic [15:0]          c,
                                             input logic [DATAWIDTH-1:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = DATAWIDTH - 1; i >= 0; i--) begin
            fb = d[i] ^ r[15];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    assign out_free = !m_valid_q || m_ready;
    assign s_ready  = ((state_q == IDLE) || (state_q == DATA)) && out_free;
    assign accept   = s_valid && s_ready;

    // The first byte of a frame uses the live mode input and starts from SEED,
    // so a single-byte frame is decided in the same cycle it is accepted.
    assign mode_eff = (state_q == IDLE) ? mode : mode_q;
    assign crc_next = crc_step((state_q == IDLE) ? SEED : lfsr_q, s_data);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        mode_d     = mode_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        crc_out_d  = crc_out_q;
        crc_done_d = 1'b0;
        crc_err_d  = crc_err_q;

        // A free output register drains unless something reloads it below.
        if (out_free) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                    lfsr_d    = crc_next;
                    if (state_q == IDLE) begin
                        mode_d = mode;
                    end
                    if (s_last) begin
                        m_last_d   = mode_eff;
                        crc_done_d = 1'b1;
                        crc_out_d  = crc_next;
                        crc_err_d  = mode_eff && (crc_next != 16'h0000);
                        state_d    = mode_eff ? STAT : CRC_HI;
                    end else begin
                        m_last_d = 1'b0;
                        state_d  = DATA;
                    end
                end
            end
            CRC_HI: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = lfsr_q[15 -: DATAWIDTH];
                    m_last_d  = 1'b0;
                    state_d   = CRC_LO;
                end
            end
            CRC_LO: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = lfsr_q[DATAWIDTH-1:0];
                    m_last_d  = 1'b1;
                    lfsr_d    = SEED;
                    state_d   = IDLE;
                end
            end
            STAT: begin
                lfsr_d  = SEED;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            mode_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            crc_out_q  <= 16'h0000;
            crc_done_q <= 1'b0;
            crc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            mode_q     <= mode_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            crc_out_q  <= crc_out_d;
            crc_done_q <= crc_done_d;
            crc_err_q  <= crc_err_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign crc_out  = crc_out_q;
    assign crc_done = crc_done_q;
    assign crc_err  = crc_err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_crc16_frame_ctrl
//
// Directed and randomized frames are queued as bytes, a frame-level model
// (table-driven CRC) predicts the downstream beats and per-frame CRC results,
// and a negedge monitor collects what the DUT produces.
// ----------------------------------------------------------------------------
module tb_crc16_frame_ctrl;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] crc_out;
    logic        crc_done;
    logic        crc_err;
    logic        busy;

    int checks = 0;
    int failures = 0;

    crc16_frame_ctrl #(.SEED(16'hFFFF), .DATAWIDTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .crc_out(crc_out), .crc_done(crc_done), .crc_err(crc_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // stimulus queue
    logic [7:0]  tx_data[$];
    logic        tx_last[$];
    logic        tx_mode[$];
    // observed
    logic [7:0]  got_d[$];
    logic        got_l[$];
    logic [15:0] dn_crc[$];
    logic        dn_err[$];
    // expected
    logic [7:0]  exp_d[$];
    logic        exp_l[$];
    logic [15:0] exp_crc[$];
    logic        exp_err[$];
    int          exp_stalls;

    logic [15:0] tbl[256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] upd(input logic [15:0] c, input logic [7:0] d);
        return {c[7:0], 8'h00} ^ tbl[c[15:8] ^ d];
    endfunction

    function automatic logic [15:0] crc_of(input bq_t b);
        logic [15:0] c = 16'hFFFF;
        foreach (b[k]) c = upd(c, b[k]);
        return c;
    endfunction

    function automatic logic [15:0] crc_at(input int i);
        return (i < dn_crc.size()) ? dn_crc[i] : 16'hxxxx;
    endfunction

    function automatic logic err_at(input int i);
        return (i < dn_err.size()) ? dn_err[i] : 1'bx;
    endfunction

    task automatic add_frame(input bq_t b, input logic md, input logic tog);
        for (int k = 0; k < b.size(); k++) begin
            tx_data.push_back(b[k]);
            tx_last.push_back(k == b.size() - 1);
            tx_mode.push_back(tog ? (md ^ k[0]) : md);
        end
    endtask

    // Frame-level reference: payload passes through; generate frames gain
    // the CRC high/low bytes; check frames mark the last byte themselves.
    task automatic build_model();
        logic        fm = 1'b0;
        logic [15:0] c = 16'hFFFF;
        logic        start = 1'b1;
        exp_d.delete(); exp_l.delete(); exp_crc.delete(); exp_err.delete();
        exp_stalls = 0;
        for (int i = 0; i < tx_data.size(); i++) begin
            if (start) begin
                fm = tx_mode[i];
                c  = 16'hFFFF;
            end
            c = upd(c, tx_data[i]);
            exp_d.push_back(tx_data[i]);
            exp_l.push_back(tx_last[i] & fm);
            start = tx_last[i];
            if (tx_last[i]) begin
                if (!fm) begin
                    exp_d.push_back(c[15:8]); exp_l.push_back(1'b0);
                    exp_d.push_back(c[7:0]);  exp_l.push_back(1'b1);
                end
                exp_crc.push_back(c);
                exp_err.push_back(fm && (c != 16'h0000));
                if (i != tx_data.size() - 1) exp_stalls += fm ? 1 : 2;
            end
        end
    endtask

    task automatic set_ready(input int bp);
        if (bp == 1)      m_ready = ~m_ready;
        else if (bp == 2) m_ready = 1'($urandom_range(0, 1));
        else              m_ready = 1'b1;
    endtask

    task automatic drive(input int bp, input int gap, input int stop_after, output int stalls);
        int idx = 0;
        int cyc = 0;
        stalls = 0;
        while (idx < tx_data.size() && idx < stop_after && cyc < 5000) begin
            @(posedge clk); #1;
            set_ready(bp);
            s_valid = (gap != 0 && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            s_data  = tx_data[idx];
            s_last  = tx_last[idx];
            mode    = tx_mode[idx];
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            else if (s_valid && bp == 0) stalls++;
            cyc++;
        end
        chk("drive_in_budget", 32'(cyc < 5000), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic drain(input int bp);
        int cyc = 0;
        while (!(got_d.size() >= exp_d.size() && dn_crc.size() >= exp_crc.size()) && cyc < 3000) begin
            set_ready(bp);
            @(negedge clk);
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_in_budget", 32'(cyc < 3000), 32'd1);
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input int bp, input int gap);
        int st;
        got_d.delete(); got_l.delete(); dn_crc.delete(); dn_err.delete();
        build_model();
        drive(bp, gap, 32'h7fffffff, st);
        drain(bp);
        chk({tag, "_beats"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), (i < got_d.size()) ? got_d[i] : 8'hxx, exp_d[i]);
            chk($sformatf("%s_last%0d", tag, i), (i < got_l.size()) ? got_l[i] : 1'bx, exp_l[i]);
        end
        chk({tag, "_frames"}, dn_crc.size(), exp_crc.size());
        for (int i = 0; i < exp_crc.size(); i++) begin
            chk($sformatf("%s_crc%0d", tag, i), crc_at(i), exp_crc[i]);
            chk($sformatf("%s_err%0d", tag, i), err_at(i), exp_err[i]);
        end
        if (bp == 0 && gap == 0) chk({tag, "_stalls"}, st, exp_stalls);
        chk({tag, "_idle"}, busy, 1'b0);
        tx_data.delete(); tx_last.delete(); tx_mode.delete();
    endtask

    // Monitor: collects transfers, checks hold-under-backpressure and s_ready.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d;
    logic       hold_l;
    always @(negedge clk) begin
        if (!rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, hold_d);
                chk("hold_last", m_last, hold_l);
            end
            if (m_valid && !m_ready) chk("stall_s_ready", s_ready, 1'b0);
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
            end
            if (crc_done) begin
                dn_crc.push_back(crc_out);
                dn_err.push_back(crc_err);
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
        end
    end

    initial begin
        bq_t t1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        bq_t t2, t2b, fa, fz, rb;
        int  st, nl;

        for (int b = 0; b < 256; b++) begin
            logic [15:0] c;
            c = 16'(b) << 8;
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            tbl[b] = c;
        end
        t2  = t1; t2.push_back(8'h29); t2.push_back(8'hB1);
        t2b = t1; t2b.push_back(8'h29); t2b.push_back(8'hB0);
        fa  = '{8'h41};
        fz  = '{8'h00};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_crc_out", crc_out, 16'h0000);
        chk("rst_crc_done", crc_done, 1'b0);
        chk("rst_crc_err", crc_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        @(posedge clk); #1 rst = 1'b1;

        // generate "123456789"
        add_frame(t1, 1'b0, 1'b0);
        run("t1", 0, 0);
        chk("t1_crc_const", crc_at(0), 16'h29B1);

        // check with good, then bad trailer
        add_frame(t2, 1'b1, 1'b0);
        run("t2", 0, 0);
        chk("t2_residue", crc_at(0), 16'h0000);
        chk("t2_err", err_at(0), 1'b0);
        add_frame(t2b, 1'b1, 1'b0);
        run("t2b", 0, 0);
        chk("t2b_err", err_at(0), 1'b1);

        // back-to-back single-byte generate frames
        add_frame(fa, 1'b0, 1'b0);
        add_frame(fz, 1'b0, 1'b0);
        run("t3", 0, 0);
        chk("t3_crc_a", crc_at(0), 16'hB915);
        chk("t3_crc_z", crc_at(1), 16'hE1F0);

        // alternating backpressure
        add_frame(t1, 1'b0, 1'b0);
        run("t4", 1, 0);
        chk("t4_crc_const", crc_at(0), 16'h29B1);

        // reset after 4 accepted bytes
        got_d.delete(); got_l.delete(); dn_crc.delete(); dn_err.delete();
        add_frame(t1, 1'b0, 1'b0);
        drive(0, 0, 4, st);
        #2 rst = 1'b0;
        #1;
        chk("t5_m_valid", m_valid, 1'b0);
        chk("t5_m_data", m_data, 8'h00);
        chk("t5_m_last", m_last, 1'b0);
        chk("t5_crc_done", crc_done, 1'b0);
        chk("t5_crc_out", crc_out, 16'h0000);
        chk("t5_busy", busy, 1'b0);
        chk("t5_no_done", dn_crc.size(), 0);
        chk("t5_beats", got_d.size(), 3);
        nl = 0;
        foreach (got_l[k]) if (got_l[k] !== 1'b0) nl++;
        chk("t5_no_last", nl, 0);
        tx_data.delete(); tx_last.delete(); tx_mode.delete();
        @(posedge clk); #1 rst = 1'b1;
        add_frame(t1, 1'b0, 1'b0);
        run("t5r", 0, 0);
        chk("t5r_crc_const", crc_at(0), 16'h29B1);

        // mode toggled mid-frame
        add_frame(t1, 1'b0, 1'b1);
        run("t6", 0, 0);
        chk("t6_crc_const", crc_at(0), 16'h29B1);
        chk("t6_err", err_at(0), 1'b0);

        // randomized frames
        for (int it = 0; it < 12; it++) begin
            int nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                int       len = $urandom_range(1, 10);
                logic     md  = 1'($urandom_range(0, 1));
                logic [15:0] c;
                rb.delete();
                for (int k = 0; k < len; k++) rb.push_back(8'($urandom));
                if (md && $urandom_range(0, 1) == 1) begin
                    c = crc_of(rb);
                    rb.push_back(c[15:8]);
                    rb.push_back(c[7:0]);
                end
                add_frame(rb, md, 1'($urandom_range(0, 1)));
            end
            run($sformatf("rnd%0d", it), $urandom_range(0, 2), $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
